ahb_prefetch_queue: RTL and testbench

Parametrised instruction-side AHB-Lite master with a prefetch FIFO. It sits between the AHB instruction port and the decode stage of the RV32I pipeline. It replaces the single-entry, stall-coupled fetch with a pipelined address/data-phase fetcher and a DEPTH-entry queue, and adds flush-with-redirect, tolerance of wait states, and tagging of bus errors.

---
 rtl/ahb_prefetch_queue.sv | 154 +++++++++++++++
 tb/tb_ahb_prefetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_prefetch_queue.sv
// Instruction-side AHB-Lite fetcher: pipelined address/data phases feeding a DEPTH-entry prefetch queue.
// Optional macro PFQ_BYPASS_EN forwards a completing beat straight to decode when the queue is empty.
module ahb_prefetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    output logic [ADDR_W-1:0] HADDR_I,
    output logic [1:0]        HTRANS_I,
    output logic              HWRITE_I,
    output logic [2:0]        HSIZE_I,
    output logic [2:0]        HBURST_I,
    output logic [3:0]        HPROT_I,
    output logic              HMASTLOCK_I,
    output logic [DATA_W-1:0] HWDATA_I,
    input  logic [DATA_W-1:0] HRDATA_I,
    input  logic              HREADY_I,
    input  logic              HRESP_I,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    input  logic              inst_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = CW + 1;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic              r_mem_err  [DEPTH];

    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_ap_valid, r_ap_kill;
    logic [ADDR_W-1:0] r_ap_pc;
    logic              r_dp_valid, r_dp_kill;
    logic [ADDR_W-1:0] r_dp_pc;
    logic              r_halted;

    logic [ADDR_W-1:0] w_flush_pc, w_issue_pc;
    logic              w_ap_live, w_dp_live;
    logic [IW-1:0]     w_inflight;
    logic              w_issue, w_complete, w_err_start;
    logic              w_head_valid, w_bypass, w_push, w_pop;

    assign HADDR_I     = r_ap_pc;
    assign HTRANS_I    = r_ap_valid ? 2'b10 : 2'b00;
    assign HWRITE_I    = 1'b0;
    assign HSIZE_I     = 3'b010;
    assign HBURST_I    = 3'b000;
    assign HPROT_I     = 4'b0010;
    assign HMASTLOCK_I = 1'b0;
    assign HWDATA_I    = '0;

    assign w_flush_pc = flush_pc & ~ADDR_W'(3);
    assign w_ap_live  = r_ap_valid & ~r_ap_kill;
    assign w_dp_live  = r_dp_valid & ~r_dp_kill;
    assign w_inflight = IW'(r_count) + IW'(w_ap_live) + IW'(w_dp_live);

    // A flush kills everything in flight, so it always has credit and overrides halt.
    assign w_issue     = HREADY_I & (flush | (~r_halted & (w_inflight < IW'(DEPTH))));
    assign w_issue_pc  = flush ? w_flush_pc : r_fetch_pc;
    assign w_complete  = HREADY_I & w_dp_live & ~flush;
    assign w_err_start = w_dp_live & HRESP_I & ~HREADY_I & ~flush;

    assign w_head_valid = (r_count != '0);
`ifdef PFQ_BYPASS_EN
    assign w_bypass = ~w_head_valid & w_complete & ~HRESP_I;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_pop  = w_head_valid & inst_ready & ~flush;
    assign w_push = w_complete & ~(w_bypass & inst_ready);

    always_comb begin
        inst_valid = w_head_valid | w_bypass;
        inst_data  = '0;
        inst_pc    = '0;
        inst_err   = 1'b0;
        if (w_head_valid) begin
            inst_data = r_mem_data[r_rd_ptr];
            inst_pc   = r_mem_pc[r_rd_ptr];
            inst_err  = r_mem_err[r_rd_ptr];
        end else if (w_bypass) begin
            inst_data = HRDATA_I;
            inst_pc   = r_dp_pc;
        end
    end

    // Storage carries no reset; the head is masked by r_count instead.
    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= HRESP_I ? '0 : HRDATA_I;
            r_mem_pc[r_wr_ptr]   <= r_dp_pc;
            r_mem_err[r_wr_ptr]  <= HRESP_I;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_ap_valid <= 1'b0;
            r_ap_kill  <= 1'b0;
            r_ap_pc    <= RESET_PC;
            r_dp_valid <= 1'b0;
            r_dp_kill  <= 1'b0;
            r_dp_pc    <= '0;
            r_halted   <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end

            if (HREADY_I) begin
                r_dp_valid <= r_ap_valid;
                r_dp_pc    <= r_ap_pc;
                r_dp_kill  <= r_ap_kill | flush;
                r_ap_valid <= w_issue;
                r_ap_kill  <= 1'b0;
                if (w_issue) begin
                    r_ap_pc    <= w_issue_pc;
                    r_fetch_pc <= w_issue_pc + ADDR_W'(4);
                end
            end else begin
                // A held address phase must stay on the bus; it is only marked dead.
                if (flush) begin
                    r_ap_kill  <= 1'b1;
                    r_dp_kill  <= 1'b1;
                    r_fetch_pc <= w_flush_pc;
                end
                if (w_err_start) r_ap_valid <= 1'b0;
            end

            if (flush)            r_halted <= 1'b0;
            else if (w_err_start) r_halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_prefetch_queue.sv
// Directed bench for ahb_prefetch_queue: zero/wait-state slave, back-pressure, flush and bus-error cases.
module tb_ahb_prefetch_queue;
`ifdef PFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] MAGIC = 32'hA5C3_0000;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR_I;
    logic [1:0]  HTRANS_I;
    logic        HWRITE_I;
    logic [2:0]  HSIZE_I;
    logic [2:0]  HBURST_I;
    logic [3:0]  HPROT_I;
    logic        HMASTLOCK_I;
    logic [31:0] HWDATA_I;
    logic [31:0] HRDATA_I;
    logic        HREADY_I;
    logic        HRESP_I;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] err_pc;
    logic [31:0] dph_addr;
    logic [31:0] issued [$];
    int          n_issued;

    ahb_prefetch_queue dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_I(HADDR_I), .HTRANS_I(HTRANS_I), .HWRITE_I(HWRITE_I),
        .HSIZE_I(HSIZE_I), .HBURST_I(HBURST_I), .HPROT_I(HPROT_I),
        .HMASTLOCK_I(HMASTLOCK_I), .HWDATA_I(HWDATA_I), .HRDATA_I(HRDATA_I),
        .HREADY_I(HREADY_I), .HRESP_I(HRESP_I),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_err(inst_err), .inst_ready(inst_ready),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: log/verify a pop, let the slave take the accepted address phase, drive its read data.
    task automatic step();
        logic        acc, t, e;
        logic [31:0] a;
        acc = HREADY_I;
        t   = HTRANS_I[1];
        a   = HADDR_I;
        if (!HRESET && inst_valid && inst_ready && !flush) begin
            e = (exp_pc == err_pc);
            $display("POP pc=%h data=%h err=%b", inst_pc, inst_data, inst_err);
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst_data, e ? 32'h0 : (exp_pc ^ MAGIC));
            check("pop_err", {31'b0, inst_err}, {31'b0, e});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge HCLK);
        #1;
        if (acc && !HRESET) begin
            if (t) issued.push_back(a);
            dph_addr = a;
        end
        HRDATA_I = dph_addr ^ MAGIC;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        HREADY_I   = 1'b1;
        HRESP_I    = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        #1;
        check("rst_htrans", {30'b0, HTRANS_I}, 32'h0);
        check("rst_haddr", HADDR_I, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        step();
        step();
        HRESET = 1'b0;
        exp_pc = 32'h0;
        err_pc = 32'hFFFF_FFFF;
        issued.delete();
    endtask

    initial begin
        HRESET   = 1'b1;
        dph_addr = 32'h0;
        HRDATA_I = 32'h0;
        do_reset();
        check("rst_err", {31'b0, inst_err}, 32'h0);
        check("rst_data", inst_data, 32'h0);
        check("const_hsize", {29'b0, HSIZE_I}, 32'h2);
        check("const_hprot", {28'b0, HPROT_I}, 32'h2);
        check("const_hwrite", {31'b0, HWRITE_I}, 32'h0);
        check("const_hburst", {29'b0, HBURST_I}, 32'h0);

        // Zero-wait streaming with decode always ready.
        inst_ready = 1'b1;
        check("t1_idle_c0", {30'b0, HTRANS_I}, 32'h0);
        step();
        check("t1_trans_c1", {30'b0, HTRANS_I}, 32'h2);
        check("t1_addr_c1", HADDR_I, 32'h0);
        step();
        check("t1_addr_c2", HADDR_I, 32'h4);
        check("t1_valid_c2", {31'b0, inst_valid}, {31'b0, (LAT == 1)});
        step();
        check("t1_addr_c3", HADDR_I, 32'h8);
        check("t1_valid_c3", {31'b0, inst_valid}, 32'h1);
        check("t1_pc_c3", inst_pc, (LAT == 1) ? 32'h4 : 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t1_stream_valid", {31'b0, inst_valid}, 32'h1);
        end

        // Back-pressure: queue fills to DEPTH, bus goes idle, then resumes at 0x10.
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t2_issued_n", issued.size(), 32'd4);
        check("t2_last_addr", issued[3], 32'hC);
        check("t2_idle", {30'b0, HTRANS_I}, 32'h0);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t2_resume_addr", issued[4], 32'h10);

        // Three wait states on the 0x8 data phase hold 0xC on the bus.
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        HREADY_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_addr", HADDR_I, 32'hC);
            check("t3_hold_trans", {30'b0, HTRANS_I}, 32'h2);
            step();
        end
        HREADY_I = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t3_progress", exp_pc, (LAT == 1) ? 32'h28 : 32'h24);
        for (int i = 0; i < issued.size(); i++) check("t3_issue_seq", issued[i], 32'(i * 4));

        // Flush while 0x8 is in data phase and 0xC is held in address phase.
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        HREADY_I = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h102;
        exp_pc   = 32'h100;
        step();
        flush = 1'b0;
        check("t4_held_addr", HADDR_I, 32'hC);
        check("t4_held_trans", {30'b0, HTRANS_I}, 32'h2);
        check("t4_cleared", {31'b0, inst_valid}, 32'h0);
        step();
        HREADY_I = 1'b1;
        check("t4_still_held", HADDR_I, 32'hC);
        check("t4_no_stale_c6", {31'b0, inst_valid}, 32'h0);
        step();
        check("t4_redirect_addr", HADDR_I, 32'h100);
        check("t4_redirect_trans", {30'b0, HTRANS_I}, 32'h2);
        check("t4_no_stale_c7", {31'b0, inst_valid}, 32'h0);
        step();
        check("t4_next_addr", HADDR_I, 32'h104);
        for (int i = 0; i < 4; i++) step();
        check("t4_progress", exp_pc, (LAT == 1) ? 32'h110 : 32'h10C);

        // Two-cycle error response on fetch 0x20 halts fetching until a flush.
        do_reset();
        inst_ready = 1'b1;
        err_pc     = 32'h20;
        for (int i = 0; i < 10; i++) step();
        check("t5_pending_addr", HADDR_I, 32'h24);
        HREADY_I = 1'b0;
        HRESP_I  = 1'b1;
        step();
        HREADY_I = 1'b1;
        check("t5_idle_after_err", {30'b0, HTRANS_I}, 32'h0);
        step();
        HRESP_I = 1'b0;
        check("t5_err_valid", {31'b0, inst_valid}, 32'h1);
        check("t5_err_pc", inst_pc, 32'h20);
        check("t5_err_flag", {31'b0, inst_err}, 32'h1);
        check("t5_err_data", inst_data, 32'h0);
        n_issued = issued.size();
        for (int i = 0; i < 6; i++) step();
        check("t5_halted_issue", issued.size(), n_issued);
        check("t5_halted_idle", {30'b0, HTRANS_I}, 32'h0);
        check("t5_drained", {31'b0, inst_valid}, 32'h0);
        flush    = 1'b1;
        flush_pc = 32'h200;
        exp_pc   = 32'h200;
        step();
        flush = 1'b0;
        check("t5_resume_addr", HADDR_I, 32'h200);
        check("t5_resume_trans", {30'b0, HTRANS_I}, 32'h2);
        for (int i = 0; i < 5; i++) step();
        check("t5_progress", exp_pc, (LAT == 1) ? 32'h210 : 32'h20C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
